hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central pipeline hazard controller for the five-stage in-order core (IF, ID, EX, MEM, WB). It collects hazard and redirect requests from the datapath and memory interfaces and drives the per-stage stall, squash and bubble controls consumed by each stage's validity tracking. A small redirect state machine keeps stale fetch responses squashed until the fetch unit acknowledges the new PC. It sits beside the pipeline registers, one instance per core.

## Interface
- `NSTG`, 5: number of pipeline stages; bit index 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB.
- `PCNT_W`, 32: width of performance counters (only with `HAZARD_PERF_EN`).

- `clk_i` in 1: core clock; the single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `load_use_i` in 1: ID needs the result of a load currently in EX.
- `muldiv_busy_i` in 1: multi-cycle mul/div op occupying EX.
- `imem_wait_i` in 1: instruction memory has not returned the fetch this cycle.
- `dmem_wait_i` in 1: data memory access in MEM not complete.
- `branch_redirect_i` in 1: EX resolved a mispredict; new PC issued this cycle.
- `trap_redirect_i` in 1: MEM raised a trap or exception return; new PC issued this cycle.
- `fetch_ack_i` in 1: IF accepted a response for the currently requested PC.
- `stall_o` out NSTG: hold stage register.
- `squash_o` out NSTG: invalidate stage contents.
- `bubble_o` out NSTG: insert invalid slot into stage.
- `redirect_pending_o` out 1: FSM in FLUSH.
- `stall_cycles_o` out PCNT_W: cycles with any `stall_o` bit set (macro only).
- `flush_count_o` out PCNT_W: redirects accepted (macro only).

## Operation
- Combinational request decode, fixed priority (highest first):
  - trap_redirect: `squash_o`=5'b01111. Nothing is stalled.
  - dmem_wait: `stall_o`=5'b01111 and `bubble_o`[4]=1.
  - muldiv_busy: `stall_o`=5'b00111 and `bubble_o`[3]=1.
  - load_use: `stall_o`=5'b00011 and `bubble_o`[2]=1.
  - imem_wait: `stall_o`[0]=1 and `bubble_o`[1]=1.
- Lower-priority stall/bubble terms are suppressed when a higher-priority term is active.
- `branch_redirect_i` is OR-combined and is not part of the priority chain. It adds `squash_o`[1:0]=2'b11 unless `dmem_wait_i` or `muldiv_busy_i` is set. In that case the branch is held in EX and is reasserted by the datapath later.
- Squash bits are asserted even while the same stage is stalled. The downstream trackers latch the squash across the stall.
- Redirect FSM, 2 states:
  - IDLE → FLUSH when a redirect is accepted (trap, or an unsuppressed branch) in the same cycle as `imem_wait_i`=1.
  - FLUSH: `squash_o`[0]=1 every cycle, OR-ed with the decode.
  - FLUSH → IDLE on `fetch_ack_i`=1 && `imem_wait_i`=0. That response is the stale one and is still squashed in that cycle.
  - A new redirect while in FLUSH stays in FLUSH; there is no counter.
- `redirect_pending_o` = (state==FLUSH).

## Timing
- Decode outputs are combinational from inputs and state, with zero-cycle latency. The FSM is registered.
- Reset, asynchronous: state=IDLE, counters=0. While `rst_ni`=0, outputs are forced to `squash_o`=5'b11111, `stall_o`=0, `bubble_o`=0 and `redirect_pending_o`=0.
- Reset mid-FLUSH returns to IDLE immediately. The first post-reset cycle decodes from inputs only.
- Simultaneous trap and branch: trap wins, `squash_o`=5'b01111, and FLUSH entry uses the same rule.
- Simultaneous `fetch_ack_i` and a new redirect in FLUSH: stay in FLUSH.
- `stall_o` and `bubble_o` never assert on the same bit in the same cycle.

## Configuration
- `HAZARD_PERF_EN` defined: two PCNT_W saturating counters are built.
  - `stall_cycles_o` increments on any `|stall_o`.
  - `flush_count_o` increments on each accepted redirect.
  - Both hold at all-ones and clear on reset.
- `HAZARD_PERF_EN` undefined: both counter ports are tied to 0 and no counter flops are built.

## Test plan
- `load_use_i`=1 for 1 cycle → `stall_o`=5'b00011, `bubble_o`=5'b00100; next cycle all outputs 0.
- `dmem_wait_i`=1 with `load_use_i`=1 and `muldiv_busy_i`=1 for 3 cycles → `stall_o`=5'b01111 and `bubble_o`=5'b10000 on all 3 cycles; `stall_cycles_o` advances by 3 (macro on).
- `branch_redirect_i`=1 with `imem_wait_i`=1 → `squash_o`=5'b00011 and FSM→FLUSH; hold `imem_wait_i` for 4 cycles → `squash_o`[0]=1 on each. Then `fetch_ack_i`=1 with `imem_wait_i`=0 → squashed that cycle, IDLE next cycle.
- `trap_redirect_i`=1 with `branch_redirect_i`=1 and `dmem_wait_i`=1 → `squash_o`=5'b01111, `stall_o`=0; `flush_count_o` increments by 1.
- `branch_redirect_i`=1 with `muldiv_busy_i`=1 → `squash_o`=0, `stall_o`=5'b00111, FSM stays IDLE.
- Deassert `rst_ni` while in FLUSH → immediately `squash_o`=5'b11111 and `redirect_pending_o`=0; counters read 0 after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: priority stall/bubble decode, redirect squash and a
// two-state redirect FSM. Define HAZARD_PERF_EN to build the saturating perf counters.
module hazard_ctrl #(
   parameter int NSTG   = 5,
   parameter int PCNT_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_use_i,
   input  logic              muldiv_busy_i,
   input  logic              imem_wait_i,
   input  logic              dmem_wait_i,
   input  logic              branch_redirect_i,
   input  logic              trap_redirect_i,
   input  logic              fetch_ack_i,
   output logic [NSTG-1:0]   stall_o,
   output logic [NSTG-1:0]   squash_o,
   output logic [NSTG-1:0]   bubble_o,
   output logic              redirect_pending_o,
   output logic [PCNT_W-1:0] stall_cycles_o,
   output logic [PCNT_W-1:0] flush_count_o
);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t state, state_nxt;
   logic   branch_ok;
   logic   redirect_accept;

   // A branch resolved while EX is held is dropped; the datapath reissues it later.
   assign branch_ok       = branch_redirect_i & ~dmem_wait_i & ~muldiv_busy_i;
   assign redirect_accept = trap_redirect_i | branch_ok;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (redirect_accept && imem_wait_i) state_nxt = FLUSH;
         FLUSH:   if (!redirect_accept && fetch_ack_i && !imem_wait_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      stall_o            = '0;
      squash_o           = '0;
      bubble_o           = '0;
      redirect_pending_o = 1'b0;
      if (!rst_ni) begin
         squash_o = '1;
      end else begin
         if (trap_redirect_i) begin
            squash_o[3:0] = '1;
         end else if (dmem_wait_i) begin
            stall_o[3:0] = '1;
            bubble_o[4]  = 1'b1;
         end else if (muldiv_busy_i) begin
            stall_o[2:0] = '1;
            bubble_o[3]  = 1'b1;
         end else if (load_use_i) begin
            stall_o[1:0] = '1;
            bubble_o[2]  = 1'b1;
         end else if (imem_wait_i) begin
            stall_o[0]  = 1'b1;
            bubble_o[1] = 1'b1;
         end
         if (branch_ok)      squash_o[1:0] = '1;
         if (state == FLUSH) squash_o[0]   = 1'b1;
         redirect_pending_o = (state == FLUSH);
      end
   end

`ifdef HAZARD_PERF_EN
   logic [PCNT_W-1:0] stall_cnt;
   logic [PCNT_W-1:0] flush_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if ((|stall_o) && (stall_cnt != '1))     stall_cnt <= stall_cnt + PCNT_W'(1);
         if (redirect_accept && (flush_cnt != '1)) flush_cnt <= flush_cnt + PCNT_W'(1);
      end
   end

   assign stall_cycles_o = stall_cnt;
   assign flush_count_o  = flush_cnt;
`else
   assign stall_cycles_o = '0;
   assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: rule-level model compared every cycle plus
// directed literal checks of the key scenarios.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lu, md, im, dm, br, tr, ack;
   logic [4:0]  stall, squash, bubble;
   logic        pending;
   logic [31:0] stall_cycles, flush_count;

   int checks = 0;
   int errors = 0;

   bit          m_pend = 1'b0;
   int unsigned m_stall_cnt = 0;
   int unsigned m_flush_cnt = 0;

   hazard_ctrl #(.NSTG(5), .PCNT_W(32)) dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .load_use_i         (lu),
      .muldiv_busy_i      (md),
      .imem_wait_i        (im),
      .dmem_wait_i        (dm),
      .branch_redirect_i  (br),
      .trap_redirect_i    (tr),
      .fetch_ack_i        (ack),
      .stall_o            (stall),
      .squash_o           (squash),
      .bubble_o           (bubble),
      .redirect_pending_o (pending),
      .stall_cycles_o     (stall_cycles),
      .flush_count_o      (flush_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // The oldest blocked stage k holds stages 0..k and injects a bubble into k+1.
   function automatic void model_out(input bit t, d, m, l, i, b, p,
                                     output logic [4:0] sq, st, bu);
      int k;
      k  = -1;
      sq = '0;
      st = '0;
      bu = '0;
      if (!t) begin
         if (d)      k = 3;
         else if (m) k = 2;
         else if (l) k = 1;
         else if (i) k = 0;
      end
      if (k >= 0) begin
         st = 5'((1 << (k + 1)) - 1);
         bu = 5'(1 << (k + 1));
      end
      if (t)              sq = 5'((1 << 4) - 1);
      if (b && !d && !m)  sq = sq | 5'd3;
      if (p)              sq = sq | 5'd1;
   endfunction

   always @(negedge clk) begin
      logic [4:0] e_sq, e_st, e_bu;
      bit         acc;
      if (!rst_n) begin
         m_pend = 1'b0;
         m_stall_cnt = 0;
         m_flush_cnt = 0;
         check("rst_squash", 32'(squash), 32'h1f);
         check("rst_stall", 32'(stall), 32'h0);
         check("rst_bubble", 32'(bubble), 32'h0);
         check("rst_pending", 32'(pending), 32'h0);
      end else begin
         model_out(tr, dm, md, lu, im, br, m_pend, e_sq, e_st, e_bu);
         check("squash", 32'(squash), 32'(e_sq));
         check("stall", 32'(stall), 32'(e_st));
         check("bubble", 32'(bubble), 32'(e_bu));
         check("pending", 32'(pending), 32'(m_pend));
         check("no_stall_bubble_overlap", 32'(stall & bubble), 32'h0);
`ifdef HAZARD_PERF_EN
         check("stall_cycles", stall_cycles, m_stall_cnt);
         check("flush_count", flush_count, m_flush_cnt);
`else
         check("stall_cycles", stall_cycles, 32'h0);
         check("flush_count", flush_count, 32'h0);
`endif
         acc = tr || (br && !dm && !md);
         if (acc)                         m_pend = m_pend | im;
         else if (m_pend && ack && !im)   m_pend = 1'b0;
         if (e_st != 0 && m_stall_cnt != 32'hffff_ffff) m_stall_cnt++;
         if (acc && m_flush_cnt != 32'hffff_ffff)       m_flush_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      {lu, md, im, dm, br, tr, ack} = '0;
   endtask

   initial begin
      logic [31:0] sc0, fc0;
      clear_in();
      rst_n = 1'b0;
      tick();
      tick();
      #2;
      check("lit_rst_squash", 32'(squash), 32'h1f);
      tick();
      rst_n = 1'b1;
      #2;
      check("lit_post_rst_squash", 32'(squash), 32'h0);

      // load-use for one cycle
      tick(); lu = 1'b1; #2;
      check("lit_lu_stall", 32'(stall), 32'h03);
      check("lit_lu_bubble", 32'(bubble), 32'h04);
      tick(); lu = 1'b0; #2;
      check("lit_lu_after", 32'({stall, squash, bubble}), 32'h0);

      // dmem wait dominates muldiv and load-use for three cycles
      tick(); dm = 1'b1; md = 1'b1; lu = 1'b1; #2;
      sc0 = stall_cycles;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin tick(); #2; end
         check("lit_dm_stall", 32'(stall), 32'h0f);
         check("lit_dm_bubble", 32'(bubble), 32'h10);
      end
      tick(); clear_in(); #2;
`ifdef HAZARD_PERF_EN
      check("lit_stall_cnt_delta", stall_cycles - sc0, 32'd3);
`else
      check("lit_stall_cnt_tied", stall_cycles, 32'd0);
`endif

      // branch during imem wait enters FLUSH
      tick(); br = 1'b1; im = 1'b1; #2;
      check("lit_br_squash", 32'(squash), 32'h03);
      check("lit_br_pending", 32'(pending), 32'h0);
      tick(); br = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         #2;
         check("lit_flush_sq0", 32'(squash[0]), 32'h1);
         check("lit_flush_pending", 32'(pending), 32'h1);
      end
      tick(); im = 1'b0; ack = 1'b1; #2;
      check("lit_ack_sq0", 32'(squash[0]), 32'h1);
      tick(); ack = 1'b0; #2;
      check("lit_idle_pending", 32'(pending), 32'h0);
      check("lit_idle_squash", 32'(squash), 32'h0);

      // trap beats branch and dmem wait
      tick(); tr = 1'b1; br = 1'b1; dm = 1'b1; #2;
      fc0 = flush_count;
      check("lit_trap_squash", 32'(squash), 32'h0f);
      check("lit_trap_stall", 32'(stall), 32'h0);
      tick(); clear_in(); #2;
`ifdef HAZARD_PERF_EN
      check("lit_flush_cnt_delta", flush_count - fc0, 32'd1);
`else
      check("lit_flush_cnt_tied", flush_count, 32'd0);
`endif
      check("lit_trap_no_flush", 32'(pending), 32'h0);

      // branch suppressed by muldiv
      tick(); br = 1'b1; md = 1'b1; #2;
      check("lit_brmd_squash", 32'(squash), 32'h0);
      check("lit_brmd_stall", 32'(stall), 32'h07);
      tick(); clear_in(); #2;
      check("lit_brmd_idle", 32'(pending), 32'h0);

      // ack coinciding with a new redirect keeps FLUSH
      tick(); tr = 1'b1; im = 1'b1;
      tick(); tr = 1'b0; im = 1'b0; ack = 1'b1; br = 1'b1; #2;
      check("lit_flush_enter", 32'(pending), 32'h1);
      tick(); br = 1'b0; ack = 1'b0; im = 1'b1; #2;
      check("lit_flush_stay", 32'(pending), 32'h1);

      // reset while in FLUSH
      tick(); clear_in(); rst_n = 1'b0; #2;
      check("lit_rstflush_squash", 32'(squash), 32'h1f);
      check("lit_rstflush_pending", 32'(pending), 32'h0);
      tick();
      tick(); rst_n = 1'b1; #2;
      check("lit_rel_stall_cnt", stall_cycles, 32'd0);
      check("lit_rel_flush_cnt", flush_count, 32'd0);
      check("lit_rel_pending", 32'(pending), 32'h0);

      // sweep every input combination, then a pseudo-random run
      for (int v = 0; v < 128; v++) begin
         tick();
         {tr, dm, md, lu, im, br, ack} = 7'(v);
      end
      for (int n = 0; n < 300; n++) begin
         tick();
         {tr, dm, md, lu, im, br, ack} = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 3) != 0) tr = 1'b0;
      end
      tick(); clear_in();
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
